dram_dir_ctrl: RTL and testbench
================================

# dram_dir_ctrl

Controller that sequences all DRAM traffic for the beverage-formula datapath. It accepts single read or write requests for one 8-bit data number, converts them to AXI-lite-style AR/R or AW/W/B transactions, and packs/unpacks the `Data_Dir` record to and from the 64-bit DRAM word. It sits between the main program FSM (`Index_Check`, `Update`, `Check_Valid_Date` actions) and the pattern-side DRAM model, and serialises all DRAM accesses so that only one transaction is outstanding at a time.

## Interface
- `BASE_ADDR`, default 17'h10000: DRAM byte address of data number 0.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_no`  in  8  `Data_No`.
- `req_wdata`  in  57  `Data_Dir` to write.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  57  `Data_Dir` read; holds the last read value otherwise.
- `rsp_err`  out  1  non-zero RESP seen; valid with `rsp_valid`.
- `ar_valid` out 1, `ar_addr` out 17, `ar_ready` in 1.
- `r_valid` in 1, `r_data` in 64, `r_resp` in 2, `r_ready` out 1.
- `aw_valid` out 1, `aw_addr` out 17, `aw_ready` in 1.
- `w_valid` out 1, `w_data` out 64, `w_ready` in 1.
- `b_valid` in 1, `b_resp` in 2, `b_ready` out 1.

## Operation
- States: IDLE, AR, R, AW, W, B, RSP.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_write`, `req_no`, `req_wdata` and go to AR (read) or AW (write).
- Address: `BASE_ADDR + {req_no, 3'b000}`, 17 bits, with no overflow checking. `req_no`=255 gives 17'h107F8.
- AR: `ar_valid`=1 with a stable address. Advance to R on `ar_ready`.
- R: `r_ready`=1. On `r_valid`, unpack `r_data` into `rsp_rdata`, set `rsp_err`=(`r_resp`!=0), and go to RSP.
- AW: `aw_valid`=1. Advance to W on `aw_ready`.
- W: `w_valid`=1 and `w_data` is stable. Advance to B on `w_ready`.
- B: `b_ready`=1. On `b_valid`, set `rsp_err`=(`b_resp`!=0) and go to RSP.
- RSP: `rsp_valid`=1 for exactly one cycle, then return to IDLE.
- DRAM word layout:
  - [63:52] Index_A
  - [51:40] Index_B
  - [39:32] Month, zero-extended
  - [31:20] Index_C
  - [19:8] Index_D
  - [7:0] Day, zero-extended
- Unpack ignores bits [39:36] and [7:5]. Pack writes zeros to those bits.
- AR/AW and W are never asserted together. AW always completes before W asserts.
- `rsp_err` does not alter sequencing. The requester decides the warning.

## Timing
- Reset values:
  - `req_ready`=0 during reset, and 1 from the first cycle after release.
  - All valid and ready outputs = 0.
  - `ar_addr`, `aw_addr`, `w_data`, `rsp_rdata` = 0.
  - `rsp_err`=0. FSM = IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Read latency: `ar_valid` rises the cycle after acceptance. `rsp_valid` rises the cycle after the `r_valid`&`r_ready` beat. The minimum is 4 cycles from acceptance to `rsp_valid`.
- Write: `aw_valid` rises the cycle after acceptance. `w_valid` rises the cycle after the AW handshake. `b_ready` rises the cycle after the W handshake. `rsp_valid` follows the B beat by one cycle. The minimum is 5 cycles.
- A valid stays asserted until its handshake, including when ready is held low indefinitely.
- `req_valid` while not IDLE is ignored and is not queued.
- `r_valid`/`b_valid` arriving in a state that does not expect them is ignored.
- Reset asserted mid-transaction: all valids drop in the same cycle (asynchronously), the FSM returns to IDLE, and the transaction is abandoned without any response.

## Configuration
- `DRAM_DIR_CACHE_EN` defined: a one-entry write-through cache holding {valid, no, `Data_Dir`}.
  - A read hit on a valid entry goes IDLE→RSP with no AXI traffic, giving `rsp_valid` 2 cycles after acceptance and `rsp_err`=0.
  - Every completed read, and every completed write with a zero RESP, fills the cache.
  - A write with a non-zero RESP invalidates the entry.
  - Reset invalidates the entry.
- Macro undefined: no cache logic is present, and every request issues a DRAM transaction.

## Test plan
- Read `req_no`=8'h05, with DRAM returning 64'hABC123_0C_456789_1F after 3 stall cycles on each channel -> `ar_addr`=17'h10028; `rsp_rdata`={A=12'hABC, B=12'h123, C=12'h456, D=12'h789, M=4'hC, D=5'h1F}; `rsp_err`=0.
- Write `req_no`=8'hFF with {A=1, B=2, C=3, D=4, M=12, D=31} -> `aw_addr`=17'h107F8; `w_data`=64'h001002_0C_003004_1F; `w_valid` only after the AW handshake; one `rsp_valid` after the B beat.
- Read with `r_resp`=2'b10 -> `rsp_err`=1 for that pulse; the FSM is back in IDLE the next cycle.
- `req_valid` held high during a read in progress -> the second request is not accepted until `req_ready` returns, and exactly one AR is issued per accepted request.
- Assert `rst` while in the W state with `w_valid`=1 -> `w_valid`=0 immediately, no `rsp_valid`, and `req_ready`=1 after release.
- With `DRAM_DIR_CACHE_EN` defined: write no 7, then read no 7 -> the read takes 2 cycles with no `ar_valid`. A read of no 8 then issues an AR.

Source files
------------

// File: rtl/dram_dir_ctrl.sv
// dram_dir_ctrl: serialises Data_Dir reads and writes onto an AXI-lite style DRAM port.
// One request is accepted in idle and converted to AR/R or AW/W/B. The 57-bit Data_Dir record
// is packed into or unpacked from the 64-bit DRAM word. Only one transaction is in flight.
//
// Data_Dir layout (57 bits): {Index_A[56:45], Index_B[44:33], Index_C[32:21], Index_D[20:9],
//                             Month[8:5], Day[4:0]}
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req_*_i / req_ready_o         request: valid, write, data number, write data
//   rsp_valid_o, rsp_rdata_o,     one-cycle completion pulse, last read record,
//   rsp_err_o                     non-zero RESP flag
//   ar_*, r_*, aw_*, w_*, b_*     DRAM address/data channels
//
// Optional feature: define DRAM_DIR_CACHE_EN to add a one-entry write-through cache.
// Every output is a register; no input reaches an output combinationally.
module dram_dir_ctrl #(
  parameter logic [16:0] BaseAddr = 17'h10000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [7:0]  req_no_i,
  input  logic [56:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [56:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        ar_valid_o,
  output logic [16:0] ar_addr_o,
  input  logic        ar_ready_i,
  input  logic        r_valid_i,
  input  logic [63:0] r_data_i,
  input  logic [1:0]  r_resp_i,
  output logic        r_ready_o,
  output logic        aw_valid_o,
  output logic [16:0] aw_addr_o,
  input  logic        aw_ready_i,
  output logic        w_valid_o,
  output logic [63:0] w_data_o,
  input  logic        w_ready_i,
  input  logic        b_valid_i,
  input  logic [1:0]  b_resp_i,
  output logic        b_ready_o
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StRsp} state_e;

  state_e      state_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [56:0] rsp_rdata_q;
  logic        ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
  logic [16:0] ar_addr_q, aw_addr_q;
  logic [63:0] w_data_q;

  logic [16:0] req_addr;
  logic [56:0] r_dir;
  logic        unused_rdata;

  // Address wraps within 17 bits by design.
  assign req_addr = BaseAddr + {6'b0, req_no_i, 3'b000};

  assign r_dir = {r_data_i[63:52], r_data_i[51:40], r_data_i[31:20], r_data_i[19:8],
                  r_data_i[35:32], r_data_i[4:0]};
  // Upper month bits and upper day bits of the DRAM word carry no information.
  assign unused_rdata = ^{r_data_i[39:36], r_data_i[7:5]};

  function automatic logic [63:0] pack_dir(input logic [56:0] d);
    return {d[56:45], d[44:33], 4'b0000, d[8:5], d[32:21], d[20:9], 3'b000, d[4:0]};
  endfunction

`ifdef DRAM_DIR_CACHE_EN
  logic        cache_vld_q;
  logic [7:0]  cache_no_q, req_no_q;
  logic [56:0] cache_data_q, req_wdata_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      b_ready_q   <= 1'b0;
`ifdef DRAM_DIR_CACHE_EN
      cache_vld_q  <= 1'b0;
      cache_no_q   <= '0;
      cache_data_q <= '0;
      req_no_q     <= '0;
      req_wdata_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // req_ready_q gates acceptance so nothing is taken on the first edge after reset.
          if (req_ready_q && req_valid_i) begin
            req_ready_q <= 1'b0;
`ifdef DRAM_DIR_CACHE_EN
            req_no_q    <= req_no_i;
            req_wdata_q <= req_wdata_i;
            if (!req_write_i && cache_vld_q && (cache_no_q == req_no_i)) begin
              state_q     <= StRsp;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= cache_data_q;
              rsp_err_q   <= 1'b0;
            end else
`endif
            if (req_write_i) begin
              state_q    <= StAw;
              aw_valid_q <= 1'b1;
              aw_addr_q  <= req_addr;
              w_data_q   <= pack_dir(req_wdata_i);
            end else begin
              state_q    <= StAr;
              ar_valid_q <= 1'b1;
              ar_addr_q  <= req_addr;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StAr: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= StR;
          end
        end
        StR: begin
          if (r_valid_i) begin
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= r_dir;
            rsp_err_q   <= |r_resp_i;
            state_q     <= StRsp;
`ifdef DRAM_DIR_CACHE_EN
            cache_vld_q  <= 1'b1;
            cache_no_q   <= req_no_q;
            cache_data_q <= r_dir;
`endif
          end
        end
        StAw: begin
          if (aw_ready_i) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            state_q    <= StW;
          end
        end
        StW: begin
          if (w_ready_i) begin
            w_valid_q <= 1'b0;
            b_ready_q <= 1'b1;
            state_q   <= StB;
          end
        end
        StB: begin
          if (b_valid_i) begin
            b_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= |b_resp_i;
            state_q     <= StRsp;
`ifdef DRAM_DIR_CACHE_EN
            // A failed write leaves DRAM contents unknown, so drop the entry.
            if (b_resp_i == 2'b00) begin
              cache_vld_q  <= 1'b1;
              cache_no_q   <= req_no_q;
              cache_data_q <= req_wdata_q;
            end else begin
              cache_vld_q <= 1'b0;
            end
`endif
          end
        end
        StRsp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign ar_valid_o  = ar_valid_q;
  assign ar_addr_o   = ar_addr_q;
  assign r_ready_o   = r_ready_q;
  assign aw_valid_o  = aw_valid_q;
  assign aw_addr_o   = aw_addr_q;
  assign w_valid_o   = w_valid_q;
  assign w_data_o    = w_data_q;
  assign b_ready_o   = b_ready_q;

endmodule

// File: tb/tb_dram_dir_ctrl.sv
// Directed self-checking bench for dram_dir_ctrl.
module tb_dram_dir_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_no;
  logic [56:0] req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [16:0] ar_addr, aw_addr;
  logic [63:0] r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dram_dir_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_no_i    (req_no),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .ar_valid_o  (ar_valid),
    .ar_addr_o   (ar_addr),
    .ar_ready_i  (ar_ready),
    .r_valid_i   (r_valid),
    .r_data_i    (r_data),
    .r_resp_i    (r_resp),
    .r_ready_o   (r_ready),
    .aw_valid_o  (aw_valid),
    .aw_addr_o   (aw_addr),
    .aw_ready_i  (aw_ready),
    .w_valid_o   (w_valid),
    .w_data_o    (w_data),
    .w_ready_i   (w_ready),
    .b_valid_i   (b_valid),
    .b_resp_i    (b_resp),
    .b_ready_o   (b_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_ar;
    int n_rsp;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_no = '0; req_wdata = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    tick(); tick();

    // Reset state
    check("rst_req_ready", {63'b0, req_ready}, 64'd0);
    check("rst_valids", {58'b0, ar_valid, aw_valid, w_valid, rsp_valid, r_ready, b_ready}, 64'd0);
    check("rst_ar_addr", {47'b0, ar_addr}, 64'd0);
    check("rst_aw_addr", {47'b0, aw_addr}, 64'd0);
    check("rst_w_data", w_data, 64'd0);
    check("rst_rdata", {7'b0, rsp_rdata}, 64'd0);
    check("rst_err", {63'b0, rsp_err}, 64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {63'b0, req_ready}, 64'd1);

    // Read no 5 with three stall cycles on each channel
    req_valid = 1; req_write = 0; req_no = 8'h05;
    tick();
    req_valid = 0;
    check("rd_ar_valid", {63'b0, ar_valid}, 64'd1);
    check("rd_ar_addr", {47'b0, ar_addr}, 64'h10028);
    check("rd_busy", {63'b0, req_ready}, 64'd0);
    tick(); tick(); tick();
    check("rd_ar_hold", {62'b0, ar_valid, r_ready}, 64'b10);
    ar_ready = 1;
    tick();
    ar_ready = 0;
    check("rd_r_phase", {62'b0, ar_valid, r_ready}, 64'b01);
    tick(); tick(); tick();
    check("rd_r_hold", {62'b0, r_ready, rsp_valid}, 64'b10);
    r_valid = 1; r_data = 64'hABC123_0C_456789_1F; r_resp = 2'b00;
    tick();
    r_valid = 0;
    check("rd_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    check("rd_rdata", {7'b0, rsp_rdata},
          {7'b0, 12'hABC, 12'h123, 12'h456, 12'h789, 4'hC, 5'h1F});
    check("rd_err", {63'b0, rsp_err}, 64'd0);
    tick();
    check("rd_done", {62'b0, rsp_valid, req_ready}, 64'b01);

    // Write no 255: AW completes before W, one response after B
    req_valid = 1; req_write = 1; req_no = 8'hFF;
    req_wdata = {12'd1, 12'd2, 12'd3, 12'd4, 4'd12, 5'd31};
    tick();
    req_valid = 0;
    check("wr_aw_only", {62'b0, aw_valid, w_valid}, 64'b10);
    check("wr_aw_addr", {47'b0, aw_addr}, 64'h107F8);
    aw_ready = 1;
    tick();
    aw_ready = 0;
    check("wr_w_phase", {62'b0, aw_valid, w_valid}, 64'b01);
    check("wr_w_data", w_data, 64'h001002_0C_003004_1F);
    tick();
    check("wr_w_hold", {62'b0, w_valid, b_ready}, 64'b10);
    w_ready = 1;
    tick();
    w_ready = 0;
    check("wr_b_phase", {62'b0, w_valid, b_ready}, 64'b01);
    b_valid = 1; b_resp = 2'b00;
    tick();
    b_valid = 0;
    check("wr_rsp", {61'b0, rsp_valid, rsp_err, b_ready}, 64'b100);
    check("wr_rdata_held", {7'b0, rsp_rdata},
          {7'b0, 12'hABC, 12'h123, 12'h456, 12'h789, 4'hC, 5'h1F});
    tick();
    check("wr_one_pulse", {62'b0, rsp_valid, req_ready}, 64'b01);

    // Read with SLVERR; early r_valid during AR must be ignored
    req_valid = 1; req_write = 0; req_no = 8'h00;
    r_valid = 1; r_data = '1; r_resp = 2'b10;
    tick();
    req_valid = 0;
    check("err_ar_addr", {47'b0, ar_addr}, 64'h10000);
    ar_ready = 1;
    tick();
    ar_ready = 0;
    check("err_early_r_ignored", {62'b0, r_ready, rsp_valid}, 64'b10);
    tick();
    r_valid = 0;
    check("err_rsp", {62'b0, rsp_valid, rsp_err}, 64'b11);
    check("err_rdata_masked", {7'b0, rsp_rdata}, {7'b0, {57{1'b1}}});
    tick();
    check("err_idle", {62'b0, rsp_valid, req_ready}, 64'b01);

    // req_valid held high: one AR per accepted request
    req_valid = 1; req_write = 0; req_no = 8'h01;
    ar_ready = 1; r_valid = 1; r_data = '0; r_resp = 2'b00;
    n_ar = 0; n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ar_valid) n_ar++;
      if (rsp_valid) n_rsp++;
    end
    req_valid = 0; ar_ready = 0; r_valid = 0;
    check("hold_ar_count", 64'(n_ar), 64'd2);
    check("hold_rsp_count", 64'(n_rsp), 64'd2);
    check("hold_ready", {63'b0, req_ready}, 64'd1);
    tick();
    check("hold_no_extra", {62'b0, ar_valid, req_ready}, 64'b01);

    // Reset while in W
    req_valid = 1; req_write = 1; req_no = 8'h02; req_wdata = '1;
    tick();
    req_valid = 0;
    aw_ready = 1;
    tick();
    aw_ready = 0;
    check("rstw_w_valid", {63'b0, w_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("rstw_w_drop", {63'b0, w_valid}, 64'd0);
    check("rstw_w_data", w_data, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rstw_after", {61'b0, rsp_valid, req_ready, b_ready}, 64'b010);

`ifdef DRAM_DIR_CACHE_EN
    // Write no 7 fills the cache; read no 7 hits without AXI traffic
    req_valid = 1; req_write = 1; req_no = 8'h07;
    req_wdata = {12'h111, 12'h222, 12'h333, 12'h444, 4'h5, 5'h06};
    aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
    tick();
    req_valid = 0;
    tick(); tick(); tick();
    aw_ready = 0; w_ready = 0; b_valid = 0;
    check("c_wr_rsp", {63'b0, rsp_valid}, 64'd1);
    tick();
    req_valid = 1; req_write = 0; req_no = 8'h07;
    tick();
    req_valid = 0;
    check("c_hit", {62'b0, rsp_valid, ar_valid}, 64'b10);
    check("c_hit_data", {7'b0, rsp_rdata}, {7'b0, 12'h111, 12'h222, 12'h333, 12'h444, 4'h5, 5'h06});
    tick();
    req_valid = 1; req_no = 8'h08;
    tick();
    req_valid = 0;
    check("c_miss_ar", {63'b0, ar_valid}, 64'd1);
    check("c_miss_addr", {47'b0, ar_addr}, 64'h10040);
`else
    req_valid = 1; req_write = 0; req_no = 8'h07;
    tick();
    req_valid = 0;
    check("nc_ar", {62'b0, ar_valid, rsp_valid}, 64'b10);
    check("nc_addr", {47'b0, ar_addr}, 64'h10038);
`endif
    ar_ready = 1;
    tick();
    ar_ready = 0; r_valid = 1; r_data = '0;
    tick();
    r_valid = 0;
    check("last_rsp", {63'b0, rsp_valid}, 64'd1);
    tick();
    check("last_idle", {63'b0, req_ready}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
